mo_line_buffer_pp: RTL and testbench
====================================

Name: mo_line_buffer_pp

Overview:
- Parametrised ping-pong motion-object horizontal line buffer.
- Two banks:
  - The render bank is written by the motion-object pixel stream at a loadable X position, with horizontal flip, transparency gating and right-edge clipping.
  - The display bank is read out sequentially and cleared behind the read.
- Banks swap on every line start.
- Sits between the motion-object shifter output and graphic priority control, and feeds MPX.

Parameters:
- PW, 8, pixel width in bits (palette select plus color).
- XW, 9, X counter and address width; LINE_LEN must be <= 2**XW.
- LINE_LEN, 336, visible pixels per line; each bank holds LINE_LEN entries.
- TB, 4, number of low pixel bits tested for transparency; those bits all zero means transparent.

Ports:
- MCKR, in, 1, pixel clock; all state updates on its rising edge.
- RESET_b, in, 1, synchronous active-low reset.
- LINE_START, in, 1, one-cycle pulse at the start of horizontal blank; swaps the banks.
- MO_LD, in, 1, loads the render X counter from MO_X and latches MO_FLIP.
- MO_X, in, XW, start X for the next object strip.
- MO_FLIP, in, 1, 1 = the render counter decrements after each pixel; 0 = it increments.
- MO_PIX_VLD, in, 1, MO_PIX is valid this cycle.
- MO_PIX, in, PW, motion-object pixel.
- DISP_EN, in, 1, advances display readout by one pixel.
- MPX, out, PW, display pixel, registered.
- MPX_VLD, out, 1, MPX holds a real read (1 cycle after DISP_EN).
- BANK, out, 1, index of the current display bank.
- BUSY, out, 1, clear sweep in progress.
- CLIP_CNT, out, 8, count of pixel writes dropped for X >= LINE_LEN since the last LINE_START; saturates at 255.

Behaviour:
- Reset (RESET_b=0 at a clock edge):
  - MPX=0, MPX_VLD=0, BANK=0, CLIP_CNT=0.
  - Render counter wx=0, flip=0, display counter dx=0.
  - FSM enters CLEAR.
  - Reset mid-operation aborts any write or read in that cycle; no memory write occurs on the reset edge.
- FSM CLEAR:
  - Sweeps address c=0..LINE_LEN-1, writing 0 to both banks at c each cycle.
  - BUSY=1 throughout.
  - MO_LD, MO_PIX_VLD, DISP_EN and LINE_START are ignored; MPX_VLD=0.
  - After writing c=LINE_LEN-1, goes to RUN next cycle; BUSY falls with the state change.
- FSM RUN: BUSY=0; the write and read paths below are active.
- Render path (bank ~BANK):
  - MO_LD=1: wx<=MO_X, flip<=MO_FLIP.
  - MO_PIX_VLD=1: address a = MO_X if MO_LD=1 in the same cycle, else wx.
    - If a<LINE_LEN and MO_PIX[TB-1:0]!=0, write MO_PIX to render[a].
    - If a>=LINE_LEN, no write; CLIP_CNT increments.
    - Transparent pixels write nothing and do not increment CLIP_CNT.
    - Afterwards wx <= a+1, or a-1 if the effective flip is set (MO_FLIP when MO_LD=1, else the latched flip).
    - Arithmetic is modulo 2**XW: decrement from 0 wraps to 2**XW-1, which is then clipped.
  - Later writes to the same address overwrite earlier ones (last-written wins).
- Display path (bank BANK):
  - DISP_EN=1 and dx<LINE_LEN:
    - The read of display[dx] is registered to MPX on the next cycle.
    - In the same cycle, 0 is written to display[dx] (read-before-write).
    - dx <= dx+1, and MPX_VLD=1 on the next cycle.
  - DISP_EN=1 and dx>=LINE_LEN: MPX<=0, MPX_VLD<=1, no clear, dx holds.
  - DISP_EN=0: MPX holds, MPX_VLD<=0.
- LINE_START=1 in RUN:
  - BANK<=~BANK, dx<=0, CLIP_CNT<=0.
  - A DISP_EN in the same cycle is ignored (MPX_VLD=0 next cycle).
  - A render write in the same cycle goes to the old render bank; writes from the next cycle go to the new render bank.
  - wx and flip are unaffected.
- Bank independence: the render write and the display read/clear may occur in the same cycle; each bank needs one synchronous read port and one write port at most.

Test Plan:
- Reset, then hold RESET_b=1 → BUSY=1 for exactly 336 cycles; MPX=0, BANK=0. After swap, a 336-pixel DISP_EN readout gives all MPX=0.
- MO_LD with MO_X=10, MO_FLIP=0, then pixels 0x11,0x20,0x13 (TB=4, 0x20 transparent), LINE_START, read 336 → MPX at x10=0x11, x11=0, x12=0x13, all other pixels 0.
- MO_LD with MO_X=5, MO_FLIP=1, then pixels 0x31,0x32,0x33, swap and read → x5=0x31, x4=0x32, x3=0x33.
- MO_LD with MO_X=334, flip=0, then 4 opaque pixels → x334 and x335 written; CLIP_CNT=2. On LINE_START, CLIP_CNT=0.
- Read the same bank twice across two swaps with no writes → second readout all 0 (clear-behind-read). Meanwhile, writes to the other bank during readout are present on the next line.
- Pulse RESET_b=0 mid-readout at dx=100 → MPX=0, MPX_VLD=0, BANK=0 on the next cycle, and a full CLEAR sweep is redone.

Source files
------------

// File: rtl/mo_line_buffer_pp.sv
// Ping-pong motion-object line buffer.
// The render bank takes the motion-object pixel stream at a loadable X with
// flip, transparency gating and right-edge clipping. The display bank is read
// out sequentially and each location is cleared as it is read. The banks swap
// on every line start. After reset, a clear sweep zeroes both banks.
module mo_line_buffer_pp #(
  parameter int PW       = 8,
  parameter int XW       = 9,
  parameter int LINE_LEN = 336,
  parameter int TB       = 4
) (
  input  logic          MCKR,
  input  logic          RESET_b,
  input  logic          LINE_START,
  input  logic          MO_LD,
  input  logic [XW-1:0] MO_X,
  input  logic          MO_FLIP,
  input  logic          MO_PIX_VLD,
  input  logic [PW-1:0] MO_PIX,
  input  logic          DISP_EN,
  output logic [PW-1:0] MPX,
  output logic          MPX_VLD,
  output logic          BANK,
  output logic          BUSY,
  output logic [7:0]    CLIP_CNT
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  // One bit wider than XW so that LINE_LEN == 2**XW still compares correctly.
  localparam logic [XW:0]   LEN  = (XW+1)'(LINE_LEN);
  localparam logic [XW-1:0] LAST = XW'(LINE_LEN - 1);

  logic [PW-1:0] bank0 [LINE_LEN];
  logic [PW-1:0] bank1 [LINE_LEN];

  state_t        state;
  logic [XW-1:0] c;
  logic [XW-1:0] wx;
  logic          flip;
  logic [XW:0]   dx;

  logic [XW-1:0] a;
  logic          flip_eff;
  logic          opaque;
  logic          in_range;
  logic          run;
  logic          rd_ok;
  logic          render_we;
  logic          clip_evt;
  logic          disp_rd;
  logic [XW-1:0] dx_idx;
  logic [PW-1:0] rd_data;

  logic          we0, we1;
  logic [XW-1:0] wa0, wa1;
  logic [PW-1:0] wd0, wd1;

  // Decode render/display requests and steer them onto each bank's write port.
  // NOTE: combinational logic uses blocking '=' with every output defaulted
  // first so no latch is inferred; clocked state below uses '<=' only.
  always_comb begin
    a         = MO_LD ? MO_X : wx;
    flip_eff  = MO_LD ? MO_FLIP : flip;
    opaque    = |MO_PIX[TB-1:0];
    in_range  = {1'b0, a} < LEN;
    run       = (state == S_RUN);
    rd_ok     = dx < LEN;
    render_we = run && MO_PIX_VLD && opaque && in_range;
    clip_evt  = run && MO_PIX_VLD && opaque && !in_range;
    disp_rd   = run && DISP_EN && !LINE_START && rd_ok;
    dx_idx    = dx[XW-1:0];
    rd_data   = BANK ? bank1[dx_idx] : bank0[dx_idx];

    we0 = 1'b0;  wa0 = '0;  wd0 = '0;
    we1 = 1'b0;  wa1 = '0;  wd1 = '0;
    if (RESET_b) begin
      if (!run) begin
        we0 = 1'b1;  wa0 = c;
        we1 = 1'b1;  wa1 = c;
      end else if (BANK) begin
        we0 = render_we;  wa0 = a;       wd0 = MO_PIX;
        we1 = disp_rd;    wa1 = dx_idx;
      end else begin
        we0 = disp_rd;    wa0 = dx_idx;
        we1 = render_we;  wa1 = a;       wd1 = MO_PIX;
      end
    end
  end

  // Bank storage: one write port per bank, contents zeroed by the clear sweep.
  // NOTE: the arrays have no reset branch so they map onto plain RAM; the
  // post-reset clear sweep is what gives them defined contents.
  always_ff @(posedge MCKR) begin
    if (we0) bank0[wa0] <= wd0;
    if (we1) bank1[wa1] <= wd1;
  end

  // Clear/run FSM with render counter, display counter and registered outputs.
  always_ff @(posedge MCKR) begin
    if (!RESET_b) begin
      state    <= S_CLEAR;
      BUSY     <= 1'b1;
      c        <= '0;
      wx       <= '0;
      flip     <= 1'b0;
      dx       <= '0;
      BANK     <= 1'b0;
      MPX      <= '0;
      MPX_VLD  <= 1'b0;
      CLIP_CNT <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          MPX_VLD <= 1'b0;
          if (c == LAST) begin
            state <= S_RUN;
            BUSY  <= 1'b0;
            c     <= '0;
          end else begin
            c <= c + 1'b1;
          end
        end
        S_RUN: begin
          if (MO_LD) begin
            wx   <= MO_X;
            flip <= MO_FLIP;
          end
          // Transparent and clipped pixels still advance the render counter.
          if (MO_PIX_VLD) wx <= flip_eff ? a - 1'b1 : a + 1'b1;

          if (LINE_START) begin
            BANK     <= ~BANK;
            dx       <= '0;
            CLIP_CNT <= '0;
            MPX_VLD  <= 1'b0;
          end else begin
            if (clip_evt && CLIP_CNT != 8'hFF) CLIP_CNT <= CLIP_CNT + 1'b1;
            if (DISP_EN) begin
              MPX_VLD <= 1'b1;
              if (rd_ok) begin
                MPX <= rd_data;
                dx  <= dx + 1'b1;
              end else begin
                MPX <= '0;
              end
            end else begin
              MPX_VLD <= 1'b0;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// Directed bench for mo_line_buffer_pp: clear sweep, placement, flip,
// clipping, clear-behind-read, concurrent render/display and mid-line reset.
module tb_mo_line_buffer_pp;

  localparam int PW = 8;
  localparam int XW = 9;
  localparam int LL = 336;

  logic          MCKR = 1'b0;
  logic          RESET_b = 1'b0;
  logic          LINE_START = 1'b0;
  logic          MO_LD = 1'b0;
  logic [XW-1:0] MO_X = '0;
  logic          MO_FLIP = 1'b0;
  logic          MO_PIX_VLD = 1'b0;
  logic [PW-1:0] MO_PIX = '0;
  logic          DISP_EN = 1'b0;
  logic [PW-1:0] MPX;
  logic          MPX_VLD;
  logic          BANK;
  logic          BUSY;
  logic [7:0]    CLIP_CNT;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] got     [LL];
  logic          got_vld [LL];
  logic [PW-1:0] exp_px  [LL];

  mo_line_buffer_pp #(.PW(PW), .XW(XW), .LINE_LEN(LL), .TB(4)) dut (
    .MCKR       (MCKR),
    .RESET_b    (RESET_b),
    .LINE_START (LINE_START),
    .MO_LD      (MO_LD),
    .MO_X       (MO_X),
    .MO_FLIP    (MO_FLIP),
    .MO_PIX_VLD (MO_PIX_VLD),
    .MO_PIX     (MO_PIX),
    .DISP_EN    (DISP_EN),
    .MPX        (MPX),
    .MPX_VLD    (MPX_VLD),
    .BANK       (BANK),
    .BUSY       (BUSY),
    .CLIP_CNT   (CLIP_CNT)
  );

  always #5 MCKR = ~MCKR;

  // ---- stimulus helpers (entered and left on a falling edge) ----
  task automatic pulse_ls();
    LINE_START = 1'b1;
    @(negedge MCKR);
    LINE_START = 1'b0;
  endtask

  task automatic load(input logic [XW-1:0] x, input logic f);
    MO_LD = 1'b1; MO_X = x; MO_FLIP = f;
    @(negedge MCKR);
    MO_LD = 1'b0;
  endtask

  task automatic pix(input logic [PW-1:0] p);
    MO_PIX_VLD = 1'b1; MO_PIX = p;
    @(negedge MCKR);
    MO_PIX_VLD = 1'b0;
  endtask

  task automatic read_line();
    DISP_EN = 1'b1;
    for (int i = 0; i < LL; i++) begin
      @(negedge MCKR);
      got[i]     = MPX;
      got_vld[i] = MPX_VLD;
    end
    DISP_EN = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < LL; i++) exp_px[i] = '0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 2000) begin
      n++;
      @(negedge MCKR);
    end
  endtask

  // ---- tests ----
  task automatic test_reset();
    int n;
    RESET_b = 1'b0;
    repeat (3) @(negedge MCKR);
    total++; if (MPX !== 8'h00)    begin bad++; $display("FAIL reset_mpx: got %h want 00", MPX); end
    total++; if (MPX_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", MPX_VLD); end
    total++; if (BANK !== 1'b0)    begin bad++; $display("FAIL reset_bank: got %b want 0", BANK); end
    total++; if (CLIP_CNT !== 8'd0) begin bad++; $display("FAIL reset_clip: got %0d want 0", CLIP_CNT); end
    total++; if (BUSY !== 1'b1)    begin bad++; $display("FAIL reset_busy: got %b want 1", BUSY); end
    RESET_b = 1'b1;
    measure_busy(n);
    total++; if (n != LL) begin bad++; $display("FAIL busy_len: got %0d want %0d", n, LL); end
    total++; if (BANK !== 1'b0) begin bad++; $display("FAIL post_clear_bank: got %b want 0", BANK); end
    total++; if (MPX !== 8'h00) begin bad++; $display("FAIL post_clear_mpx: got %h want 00", MPX); end
  endtask

  task automatic test_empty();
    pulse_ls();
    total++; if (BANK !== 1'b1) begin bad++; $display("FAIL empty_bank: got %b want 1", BANK); end
    clear_exp();
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL empty_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
  endtask

  task automatic test_basic();
    load(9'd10, 1'b0);
    pix(8'h11); pix(8'h20); pix(8'h13);
    pulse_ls();
    total++; if (BANK !== 1'b0) begin bad++; $display("FAIL basic_bank: got %b want 0", BANK); end
    clear_exp();
    exp_px[10] = 8'h11;
    exp_px[12] = 8'h13;
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL basic_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
    // Reading past the end of the line yields valid zeros.
    DISP_EN = 1'b1;
    @(negedge MCKR);
    DISP_EN = 1'b0;
    total++; if (MPX_VLD !== 1'b1 || MPX !== 8'h00) begin
      bad++; $display("FAIL overrun: got %h vld %b want 00 vld 1", MPX, MPX_VLD);
    end
    @(negedge MCKR);
    total++; if (MPX_VLD !== 1'b0) begin bad++; $display("FAIL idle_vld: got %b want 0", MPX_VLD); end
  endtask

  task automatic test_flip();
    load(9'd5, 1'b1);
    pix(8'h31); pix(8'h32); pix(8'h33);
    // DISP_EN coinciding with LINE_START is ignored.
    LINE_START = 1'b1; DISP_EN = 1'b1;
    @(negedge MCKR);
    LINE_START = 1'b0; DISP_EN = 1'b0;
    total++; if (MPX_VLD !== 1'b0) begin bad++; $display("FAIL swap_disp_vld: got %b want 0", MPX_VLD); end
    total++; if (BANK !== 1'b1)    begin bad++; $display("FAIL flip_bank: got %b want 1", BANK); end
    clear_exp();
    exp_px[5] = 8'h31;
    exp_px[4] = 8'h32;
    exp_px[3] = 8'h33;
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL flip_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
  endtask

  task automatic test_clip();
    load(9'd334, 1'b0);
    pix(8'h41); pix(8'h42); pix(8'h43); pix(8'h44);
    total++; if (CLIP_CNT !== 8'd2) begin bad++; $display("FAIL clip_cnt2: got %0d want 2", CLIP_CNT); end
    // Decrement from 0 wraps to 511, which is clipped.
    load(9'd0, 1'b1);
    pix(8'h45); pix(8'h46);
    total++; if (CLIP_CNT !== 8'd3) begin bad++; $display("FAIL clip_wrap: got %0d want 3", CLIP_CNT); end
    pix(8'h50);
    total++; if (CLIP_CNT !== 8'd3) begin bad++; $display("FAIL clip_transp: got %0d want 3", CLIP_CNT); end
    pulse_ls();
    total++; if (CLIP_CNT !== 8'd0) begin bad++; $display("FAIL clip_reset: got %0d want 0", CLIP_CNT); end
    total++; if (BANK !== 1'b0)     begin bad++; $display("FAIL clip_bank: got %b want 0", BANK); end
    clear_exp();
    exp_px[334] = 8'h41;
    exp_px[335] = 8'h42;
    exp_px[0]   = 8'h45;
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL clip_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Bank 1 was last read in test_flip; it must now be empty.
    pulse_ls();
    total++; if (BANK !== 1'b1) begin bad++; $display("FAIL b2b_bank1: got %b want 1", BANK); end
    clear_exp();
    fork
      read_line();
      begin
        load(9'd200, 1'b0);
        pix(8'h77); pix(8'h78);
      end
    join
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL reread_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
    pulse_ls();
    total++; if (BANK !== 1'b0) begin bad++; $display("FAIL b2b_bank0: got %b want 0", BANK); end
    exp_px[200] = 8'h77;
    exp_px[201] = 8'h78;
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL concur_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    load(9'd99, 1'b0);  pix(8'h5A);
    load(9'd250, 1'b0); pix(8'h6B);
    pulse_ls();
    DISP_EN = 1'b1;
    repeat (100) @(negedge MCKR);
    total++; if (MPX !== 8'h5A || MPX_VLD !== 1'b1) begin
      bad++; $display("FAIL mid_px99: got %h vld %b want 5a vld 1", MPX, MPX_VLD);
    end
    RESET_b = 1'b0;
    @(negedge MCKR);
    DISP_EN = 1'b0;
    total++; if (MPX !== 8'h00)    begin bad++; $display("FAIL mid_rst_mpx: got %h want 00", MPX); end
    total++; if (MPX_VLD !== 1'b0) begin bad++; $display("FAIL mid_rst_vld: got %b want 0", MPX_VLD); end
    total++; if (BANK !== 1'b0)    begin bad++; $display("FAIL mid_rst_bank: got %b want 0", BANK); end
    RESET_b = 1'b1;
    measure_busy(n);
    total++; if (n != LL) begin bad++; $display("FAIL mid_busy_len: got %0d want %0d", n, LL); end
    pulse_ls();
    clear_exp();
    read_line();
    for (int i = 0; i < LL; i++) begin
      total++;
      if (got[i] !== exp_px[i] || got_vld[i] !== 1'b1) begin
        bad++; $display("FAIL swept_px[%0d]: got %h vld %b want %h vld 1", i, got[i], got_vld[i], exp_px[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_basic();
    test_flip();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
